// File: rtl/sha256_msg_padder.sv
// FIPS 180-4 padder: byte stream in, 512-bit blocks out; one byte per cycle, block valid the cycle after its 64th byte.
// Backpressure: in_ready is low outside ACCEPT, and a presented block holds until blk_ready takes it.
module sha256_msg_padder #(
    parameter int LEN_W = 32
) (
    input  logic         clk,
    input  logic         reset,
    input  logic [7:0]   in_data,
    input  logic         in_valid,
    input  logic         in_last,
    output logic         in_ready,
    output logic [511:0] blk_data,
    output logic         blk_valid,
    output logic         blk_last,
    input  logic         blk_ready,
    output logic         busy
);

    localparam logic [2:0] ACCEPT = 3'd0;
    localparam logic [2:0] PAD80  = 3'd1;
    localparam logic [2:0] ZERO   = 3'd2;
    localparam logic [2:0] LEN    = 3'd3;
    localparam logic [2:0] EMIT   = 3'd4;

    logic [2:0]       state;
    logic [2:0]       ret_state;
    logic [2:0]       state_nxt;
    logic [2:0]       ret_nxt;
    logic [511:0]     buffer;
    logic [5:0]       idx;
    logic [LEN_W-1:0] count;
    logic             last_flag;
    logic             set_last;
    logic             wr_en;
    logic [7:0]       wr_byte;
    logic [63:0]      bit_len;
    logic [63:0]      len_shift;
    logic             in_fire;
    logic             blk_fire;

    assign in_ready  = (state == ACCEPT);
    assign blk_valid = (state == EMIT);
    assign blk_last  = blk_valid & last_flag;
    assign blk_data  = buffer;
    assign busy      = (state != ACCEPT) || (count != '0);

    assign in_fire   = in_valid & in_ready;
    assign blk_fire  = blk_valid & blk_ready;

    // Length field bytes go out MSB first; idx 56..63 selects byte 0..7.
    assign bit_len   = 64'({count, 3'b000});
    assign len_shift = bit_len >> {~idx[2:0], 3'b000};

    always_comb begin
        wr_en     = 1'b0;
        wr_byte   = 8'h00;
        state_nxt = state;
        ret_nxt   = ret_state;
        set_last  = 1'b0;
        case (state)
            ACCEPT: begin
                if (in_fire) begin
                    wr_en   = 1'b1;
                    wr_byte = in_data;
                    if (idx == 6'd63) begin
                        state_nxt = EMIT;
                        ret_nxt   = in_last ? PAD80 : ACCEPT;
                    end else if (in_last) begin
                        state_nxt = PAD80;
                    end
                end
            end
            PAD80, ZERO: begin
                wr_en   = 1'b1;
                wr_byte = (state == PAD80) ? 8'h80 : 8'h00;
                if (idx == 6'd63) begin
                    state_nxt = EMIT;
                    ret_nxt   = ZERO;
                end else if (idx == 6'd55) begin
                    state_nxt = LEN;
                end else begin
                    state_nxt = ZERO;
                end
            end
            LEN: begin
                wr_en   = 1'b1;
                wr_byte = len_shift[7:0];
                if (idx == 6'd63) begin
                    state_nxt = EMIT;
                    ret_nxt   = ACCEPT;
                    set_last  = 1'b1;
                end
            end
            EMIT: begin
                if (blk_fire) begin
                    state_nxt = ret_state;
                end
            end
            default: begin
                state_nxt = ACCEPT;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state     <= ACCEPT;
            ret_state <= ACCEPT;
            idx       <= '0;
            count     <= '0;
            last_flag <= 1'b0;
        end else begin
            state     <= state_nxt;
            ret_state <= ret_nxt;
            if (wr_en) begin
                idx <= idx + 6'd1;
            end
            if (blk_fire) begin
                idx <= '0;
            end
            if (in_fire) begin
                count <= count + 1'b1;
            end
            if (set_last) begin
                last_flag <= 1'b1;
            end
            if (blk_fire && last_flag) begin
                count     <= '0;
                last_flag <= 1'b0;
            end
        end
    end

    // Blocks are assembled in place; every byte lane is rewritten before EMIT.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            buffer <= '0;
        end else begin
            for (int i = 0; i < 64; i++) begin
                if (wr_en && (idx == 6'(i))) begin
                    buffer[511-8*i -: 8] <= wr_byte;
                end
            end
        end
    end

endmodule

// File: tb/tb_sha256_msg_padder.sv
// Randomized bench for sha256_msg_padder against a byte-queue padding model.
module tb_sha256_msg_padder;

    typedef logic [7:0] bq_t[$];

    logic         clk = 1'b0;
    logic         reset = 1'b1;
    logic [7:0]   in_data = 8'h00;
    logic         in_valid = 1'b0;
    logic         in_last = 1'b0;
    logic         in_ready;
    logic [511:0] blk_data;
    logic         blk_valid;
    logic         blk_last;
    logic         blk_ready = 1'b0;
    logic         busy;

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    int rise_cyc = 0;
    logic rand_rdy = 1'b0;
    logic force_rdy = 1'b1;
    logic prev_valid = 1'b0;
    logic [512:0] got_q[$];
    logic [512:0] exp_q[$];

    sha256_msg_padder #(.LEN_W(32)) dut (
        .clk(clk), .reset(reset),
        .in_data(in_data), .in_valid(in_valid), .in_last(in_last), .in_ready(in_ready),
        .blk_data(blk_data), .blk_valid(blk_valid), .blk_last(blk_last),
        .blk_ready(blk_ready), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    always @(posedge clk) begin
        #1;
        blk_ready = rand_rdy ? 1'($urandom_range(0, 1)) : force_rdy;
    end

    // A block seen valid & ready at the falling edge is taken on the next rising edge.
    always @(negedge clk) begin
        if (!reset && blk_valid && blk_ready) got_q.push_back({blk_last, blk_data});
        if (blk_valid && !prev_valid) rise_cyc = cyc;
        prev_valid = blk_valid;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Padding from first principles: append 0x80, zero-fill to 56 mod 64, append bit length.
    function automatic void model(input bq_t msg);
        bq_t p;
        logic [63:0] bl;
        logic [511:0] d;
        int nb;
        p = msg;
        bl = 64'(msg.size()) * 64'd8;
        p.push_back(8'h80);
        while ((p.size() % 64) != 56) p.push_back(8'h00);
        for (int i = 7; i >= 0; i--) p.push_back(bl[8*i +: 8]);
        nb = p.size() / 64;
        exp_q.delete();
        for (int b = 0; b < nb; b++) begin
            for (int k = 0; k < 64; k++) d[511-8*k -: 8] = p[64*b+k];
            exp_q.push_back({(b == nb - 1) ? 1'b1 : 1'b0, d});
        end
    endfunction

    task automatic send_byte(input logic [7:0] b, input logic last, output int acc);
        int n;
        n = 0;
        in_data = b;
        in_last = last;
        in_valid = 1'b1;
        @(negedge clk);
        while (!in_ready && n < 1000) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            failures++;
            $display("FAIL in_ready_timeout actual=0 required=1");
        end
        @(posedge clk);
        #1;
        acc = cyc;
        in_valid = 1'b0;
        in_last = 1'b0;
    endtask

    task automatic send_msg(input bq_t msg, input bit gaps, input bit with_last, output int first_acc);
        int a;
        first_acc = 0;
        for (int i = 0; i < msg.size(); i++) begin
            send_byte(msg[i], with_last && (i == msg.size() - 1), a);
            if (i == 0) first_acc = a;
            if (gaps && $urandom_range(0, 3) == 0) begin
                repeat ($urandom_range(1, 3)) @(posedge clk);
                #1;
            end
        end
    endtask

    task automatic wait_blocks(input int n);
        int t;
        t = 0;
        while (got_q.size() < n && t < 4000) begin
            @(negedge clk);
            t++;
        end
        if (got_q.size() < n) begin
            checks++;
            failures++;
            $display("FAIL block_timeout got=%0d required=%0d", got_q.size(), n);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        repeat (2) @(negedge clk);
        checks++; if (in_ready !== 1'b1) begin failures++; $display("FAIL reset_in_ready actual=%b required=1", in_ready); end
        checks++; if (blk_valid !== 1'b0) begin failures++; $display("FAIL reset_blk_valid actual=%b required=0", blk_valid); end
        checks++; if (blk_last !== 1'b0) begin failures++; $display("FAIL reset_blk_last actual=%b required=0", blk_last); end
        checks++; if (busy !== 1'b0) begin failures++; $display("FAIL reset_busy actual=%b required=0", busy); end
        checks++; if (blk_data !== 512'd0) begin failures++; $display("FAIL reset_blk_data actual=%h required=0", blk_data); end
        reset = 1'b0;
        @(negedge clk);
        checks++; if (busy !== 1'b0 || in_ready !== 1'b1) begin
            failures++; $display("FAIL idle_after_reset busy=%b in_ready=%b required busy=0 in_ready=1", busy, in_ready);
        end
    endtask

    task automatic test_abc();
        bq_t msg;
        logic [511:0] abc_blk;
        int first;
        msg = '{8'h61, 8'h62, 8'h63};
        abc_blk = '0;
        abc_blk[511:480] = 32'h61626380;
        abc_blk[63:0] = 64'h18;
        rand_rdy = 1'b0;
        force_rdy = 1'b1;
        @(posedge clk);
        #1;
        got_q.delete();
        rise_cyc = 0;
        send_msg(msg, 1'b0, 1'b1, first);
        wait_blocks(1);
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL abc_count actual=%0d required=1", got_q.size()); end
        if (got_q.size() >= 1) begin
            checks++; if (got_q[0][511:0] !== abc_blk) begin failures++; $display("FAIL abc_data actual=%h required=%h", got_q[0][511:0], abc_blk); end
            checks++; if (got_q[0][512] !== 1'b1) begin failures++; $display("FAIL abc_last actual=%b required=1", got_q[0][512]); end
        end
        checks++; if (rise_cyc - first !== 63) begin failures++; $display("FAIL abc_latency actual=%0d required=63", rise_cyc - first); end
    endtask

    task automatic test_lengths();
        bq_t msgs[$];
        bq_t m;
        int first;
        m = {}; repeat (55) m.push_back(8'hAA); msgs.push_back(m);
        m = {}; repeat (56) m.push_back(8'hAA); msgs.push_back(m);
        m = {}; for (int i = 0; i < 64; i++) m.push_back(8'(i)); msgs.push_back(m);
        m = '{8'h61, 8'h62, 8'h63}; msgs.push_back(m);
        for (int r = 0; r < 8; r++) begin
            m = {};
            repeat ($urandom_range(1, 140)) m.push_back(8'($urandom));
            msgs.push_back(m);
        end
        for (int t = 0; t < msgs.size(); t++) begin
            rand_rdy = (t >= 4);
            model(msgs[t]);
            got_q.delete();
            send_msg(msgs[t], t >= 4, 1'b1, first);
            wait_blocks(exp_q.size());
            checks++; if (got_q.size() !== exp_q.size()) begin
                failures++; $display("FAIL len%0d_blocks actual=%0d required=%0d", msgs[t].size(), got_q.size(), exp_q.size());
            end
            for (int b = 0; b < exp_q.size() && b < got_q.size(); b++) begin
                checks++; if (got_q[b] !== exp_q[b]) begin
                    failures++; $display("FAIL len%0d_blk%0d actual=%h required=%h", msgs[t].size(), b, got_q[b], exp_q[b]);
                end
            end
        end
        rand_rdy = 1'b0;
    endtask

    task automatic test_backpressure();
        bq_t msg;
        logic [511:0] d;
        logic l;
        int bad;
        int t;
        int first;
        msg = '{8'h61, 8'h62, 8'h63};
        model(msg);
        force_rdy = 1'b0;
        @(posedge clk);
        #1;
        got_q.delete();
        send_msg(msg, 1'b0, 1'b1, first);
        t = 0;
        while (!blk_valid && t < 200) begin @(negedge clk); t++; end
        checks++; if (blk_valid !== 1'b1) begin failures++; $display("FAIL bp_valid actual=%b required=1", blk_valid); end
        d = blk_data;
        l = blk_last;
        checks++; if ({l, d} !== exp_q[0]) begin failures++; $display("FAIL bp_data actual=%h required=%h", {l, d}, exp_q[0]); end
        bad = 0;
        repeat (20) begin
            @(negedge clk);
            if (blk_valid !== 1'b1 || blk_data !== d || blk_last !== l || in_ready !== 1'b0) bad++;
        end
        checks++; if (bad !== 0) begin failures++; $display("FAIL bp_stable unstable_cycles=%0d required=0", bad); end
        force_rdy = 1'b1;
        t = 0;
        while (got_q.size() < 1 && t < 50) begin @(negedge clk); t++; end
        @(negedge clk);
        checks++; if (in_ready !== 1'b1 || blk_valid !== 1'b0) begin
            failures++; $display("FAIL bp_release in_ready=%b blk_valid=%b required 1/0", in_ready, blk_valid);
        end
        checks++; if (got_q.size() !== 1) begin failures++; $display("FAIL bp_handshakes actual=%0d required=1", got_q.size()); end
    endtask

    task automatic test_reset_mid();
        bq_t msg;
        int first;
        msg = {};
        repeat (30) msg.push_back(8'($urandom));
        force_rdy = 1'b1;
        send_msg(msg, 1'b0, 1'b0, first);
        #2;
        reset = 1'b1;
        #1;
        checks++; if (in_ready !== 1'b1 || blk_valid !== 1'b0 || busy !== 1'b0 || blk_last !== 1'b0 || blk_data !== 512'd0) begin
            failures++; $display("FAIL mid_reset in_ready=%b blk_valid=%b busy=%b blk_last=%b required 1/0/0/0", in_ready, blk_valid, busy, blk_last);
        end
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk);
        #1;
        msg = '{8'h61, 8'h62, 8'h63};
        model(msg);
        got_q.delete();
        send_msg(msg, 1'b0, 1'b1, first);
        wait_blocks(1);
        checks++; if (got_q.size() !== 1 || got_q[0] !== exp_q[0]) begin
            failures++; $display("FAIL post_reset_abc blocks=%0d actual=%h required=%h", got_q.size(), (got_q.size() > 0) ? got_q[0] : 513'd0, exp_q[0]);
        end
    endtask

    initial begin
        test_reset();
        test_abc();
        test_lengths();
        test_backpressure();
        test_reset_mid();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
